// File: rtl/u_imem_port_arbiter_pkg.sv
// Shared constants, FSM state encodings and grant-source type for the IMEM
// port arbiter and its round-robin picker.
package u_imem_port_arbiter_pkg;

    // IMEM geometry
    localparam int IMEM_AW       = 8;
    localparam int DATA_W        = 32;

    // Defaults for the arbiter's tunable parameters
    localparam int BURST_MAX_DEF = 4;
    localparam int CNT_W_DEF     = 16;

    // Arbiter FSM states
    localparam logic [1:0] ARB_IDLE = 2'd0;
    localparam logic [1:0] ARB_LDR  = 2'd1;
    localparam logic [1:0] ARB_DBG  = 2'd2;

    // Which halted-mode requester was (or will be) served
    typedef enum logic {
        GNT_LDR = 1'b0,
        GNT_DBG = 1'b1
    } gnt_src_t;

    // The requester that did not win last time
    function automatic gnt_src_t rr_other(input gnt_src_t src);
        return (src == GNT_LDR) ? GNT_DBG : GNT_LDR;
    endfunction

endpackage

// File: rtl/u_imem_port_arbiter_rr_picker.sv
// Two-way round-robin picker between the program loader and debug read-back.
// Holds the last-served requester; on a tie the other one is picked.
module u_imem_rr_picker
    import u_imem_port_arbiter_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     ldr_pend,
    input  logic     dbg_pend,
    input  logic     upd_en,
    input  gnt_src_t upd_src,
    output logic     pick_vld,
    output gnt_src_t pick_src
);

    gnt_src_t last_grant_reg;
    gnt_src_t last_grant_next;

    // Next last-grant value: only changes when the arbiter leaves a service state
    always_comb begin
        last_grant_next = last_grant_reg;
        if (upd_en) begin
            last_grant_next = upd_src;
        end
    end

    // Last-grant flop; reset to debug so the loader wins the first tie
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_reg <= GNT_DBG;
        end else begin
            last_grant_reg <= last_grant_next;
        end
    end

    // Pick the sole requester, or alternate on a tie
    always_comb begin
        pick_vld = ldr_pend | dbg_pend;
        pick_src = GNT_LDR;
        if (ldr_pend && dbg_pend) begin
            pick_src = rr_other(last_grant_reg);
        end else if (dbg_pend) begin
            pick_src = GNT_DBG;
        end
    end

endmodule

// File: rtl/u_imem_port_arbiter.sv
// IMEM port arbiter. The IFU owns the port combinationally while the core
// runs; while halted, the program loader (bounded bursts when debug is
// waiting) and debug read-back share the port round-robin through a
// registered grant decision.
module u_imem_port_arbiter
    import u_imem_port_arbiter_pkg::*;
#(
    parameter int BURST_MAX = BURST_MAX_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               core_running,
    input  logic               ifu_req,
    input  logic [IMEM_AW-1:0] ifu_addr,
    output logic               ifu_gnt,
    input  logic               ldr_req,
    input  logic [IMEM_AW-1:0] ldr_addr,
    input  logic [DATA_W-1:0]  ldr_data,
    output logic               ldr_ack,
    input  logic               dbg_req,
    input  logic [IMEM_AW-1:0] dbg_addr,
    output logic               dbg_ack,
    output logic               dbg_rvld,
    output logic [DATA_W-1:0]  dbg_rdata,
    output logic               imem_cen,
    output logic               imem_wen,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [DATA_W-1:0]  imem_wr_data,
    input  logic [DATA_W-1:0]  imem_rd_data,
    output logic [CNT_W-1:0]   ldr_wr_cnt
);

    localparam int                  BURST_W    = $clog2(BURST_MAX + 1);
    // Count value at which the write being issued is the BURST_MAX-th of the burst
    localparam logic [BURST_W-1:0]  BURST_LAST = BURST_W'(BURST_MAX - 1);
    localparam logic [BURST_W-1:0]  BURST_TOP  = BURST_W'(BURST_MAX);
    localparam logic [CNT_W-1:0]    CNT_SAT    = {CNT_W{1'b1}};

    logic [1:0]         state_reg;
    logic [1:0]         state_next;
    logic [BURST_W-1:0] burst_cnt_reg;
    logic [BURST_W-1:0] burst_cnt_next;
    logic               dbg_rvld_reg;
    logic [DATA_W-1:0]  dbg_rdata_reg;
    logic [CNT_W-1:0]   ldr_wr_cnt_reg;
    logic [IMEM_AW-1:0] addr_hold_reg;
    logic [DATA_W-1:0]  wdata_hold_reg;

    logic               halted;
    logic               ldr_fire;
    logic               dbg_fire;
    logic               rr_upd;
    gnt_src_t           rr_upd_src;
    logic               pick_vld;
    gnt_src_t           pick_src;

    logic               sel_fetch;
    logic               sel_ldr;
    logic               sel_dbg;
    logic               sel_hold;

    // Loader/debug may only use the port while the core is halted and out of reset
    assign halted = ~core_running & ~rst;

    u_imem_rr_picker u_picker (
        .clk      (clk),
        .rst      (rst),
        .ldr_pend (ldr_req),
        .dbg_pend (dbg_req),
        .upd_en   (rr_upd),
        .upd_src  (rr_upd_src),
        .pick_vld (pick_vld),
        .pick_src (pick_src)
    );

    // Arbiter FSM next-state, burst counting and per-cycle issue decisions
    always_comb begin
        state_next     = state_reg;
        burst_cnt_next = burst_cnt_reg;
        ldr_fire       = 1'b0;
        dbg_fire       = 1'b0;
        rr_upd         = 1'b0;
        rr_upd_src     = GNT_LDR;
        case (state_reg)
            ARB_IDLE: begin
                burst_cnt_next = '0;
                if (halted && pick_vld) begin
                    state_next = (pick_src == GNT_LDR) ? ARB_LDR : ARB_DBG;
                end
            end
            ARB_LDR: begin
                if (!halted || !ldr_req) begin
                    // Core resumed or loader finished: give up the port
                    state_next     = ARB_IDLE;
                    burst_cnt_next = '0;
                    rr_upd         = 1'b1;
                    rr_upd_src     = GNT_LDR;
                end else begin
                    ldr_fire = 1'b1;
                    if (burst_cnt_reg != BURST_TOP) begin
                        burst_cnt_next = burst_cnt_reg + 1'b1;
                    end
                    // Burst is only capped when debug is actually waiting
                    if (dbg_req && (burst_cnt_reg >= BURST_LAST)) begin
                        state_next     = ARB_IDLE;
                        burst_cnt_next = '0;
                        rr_upd         = 1'b1;
                        rr_upd_src     = GNT_LDR;
                    end
                end
            end
            ARB_DBG: begin
                state_next = ARB_IDLE;
                if (halted && dbg_req) begin
                    dbg_fire   = 1'b1;
                    rr_upd     = 1'b1;
                    rr_upd_src = GNT_DBG;
                end
            end
            default: begin
                state_next     = ARB_IDLE;
                burst_cnt_next = '0;
            end
        endcase
    end

    // FSM state and burst counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ARB_IDLE;
            burst_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            burst_cnt_reg <= burst_cnt_next;
        end
    end

    // Debug read-return pipe: valid one cycle after the read, data held afterwards
    always_ff @(posedge clk) begin
        if (rst) begin
            dbg_rvld_reg  <= 1'b0;
            dbg_rdata_reg <= '0;
        end else begin
            dbg_rvld_reg <= dbg_fire;
            if (dbg_rvld_reg) begin
                dbg_rdata_reg <= imem_rd_data;
            end
        end
    end

    // Saturating count of loader writes issued
    always_ff @(posedge clk) begin
        if (rst) begin
            ldr_wr_cnt_reg <= '0;
        end else if (ldr_fire && (ldr_wr_cnt_reg != CNT_SAT)) begin
            ldr_wr_cnt_reg <= ldr_wr_cnt_reg + 1'b1;
        end
    end

    // Last driven address and write data, replayed on idle cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_hold_reg  <= '0;
            wdata_hold_reg <= '0;
        end else begin
            if (imem_cen) begin
                addr_hold_reg <= imem_addr;
            end
            if (ldr_fire) begin
                wdata_hold_reg <= ldr_data;
            end
        end
    end

    // One-hot address source; fetch and loader/debug are exclusive through halted
    assign sel_fetch = ifu_gnt;
    assign sel_ldr   = ldr_fire;
    assign sel_dbg   = dbg_fire;
    assign sel_hold  = ~(sel_fetch | sel_ldr | sel_dbg);

    genvar gi;
    generate
        for (gi = 0; gi < IMEM_AW; gi++) begin : g_addr_mux
            assign imem_addr[gi] = (sel_fetch & ifu_addr[gi])
                                 | (sel_ldr   & ldr_addr[gi])
                                 | (sel_dbg   & dbg_addr[gi])
                                 | (sel_hold  & addr_hold_reg[gi]);
        end
    endgenerate

    assign ifu_gnt      = ifu_req & core_running;
    assign ldr_ack      = ldr_fire;
    assign dbg_ack      = dbg_fire;
    assign imem_cen     = ifu_gnt | ldr_fire | dbg_fire;
    assign imem_wen     = ldr_fire;
    assign imem_wr_data = ldr_fire ? ldr_data : wdata_hold_reg;
    assign dbg_rvld     = dbg_rvld_reg;
    // Live macro output in the return cycle, captured copy afterwards
    assign dbg_rdata    = dbg_rvld_reg ? imem_rd_data : dbg_rdata_reg;
    assign ldr_wr_cnt   = ldr_wr_cnt_reg;

endmodule

// File: tb/tb_u_imem_port_arbiter.sv
// Scoreboard bench for the IMEM port arbiter: directed scenarios plus a
// randomized loader/debug mix against a reference memory and queue model.
module tb_u_imem_port_arbiter;
    import u_imem_port_arbiter_pkg::*;

    // Narrow write counter so saturation is reachable in a short run
    localparam int TB_CNT_W = 6;
    localparam int TB_BURST = 4;
    localparam int CNT_SAT  = (1 << TB_CNT_W) - 1;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } xact_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               core_running;
    logic               ifu_req;
    logic [7:0]         ifu_addr;
    logic               ifu_gnt;
    logic               ldr_req;
    logic [7:0]         ldr_addr;
    logic [31:0]        ldr_data;
    logic               ldr_ack;
    logic               dbg_req;
    logic [7:0]         dbg_addr;
    logic               dbg_ack;
    logic               dbg_rvld;
    logic [31:0]        dbg_rdata;
    logic               imem_cen;
    logic               imem_wen;
    logic [7:0]         imem_addr;
    logic [31:0]        imem_wr_data;
    logic [31:0]        imem_rd_data;
    logic [TB_CNT_W-1:0] ldr_wr_cnt;

    u_imem_port_arbiter #(
        .BURST_MAX (TB_BURST),
        .CNT_W     (TB_CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .core_running (core_running),
        .ifu_req      (ifu_req),
        .ifu_addr     (ifu_addr),
        .ifu_gnt      (ifu_gnt),
        .ldr_req      (ldr_req),
        .ldr_addr     (ldr_addr),
        .ldr_data     (ldr_data),
        .ldr_ack      (ldr_ack),
        .dbg_req      (dbg_req),
        .dbg_addr     (dbg_addr),
        .dbg_ack      (dbg_ack),
        .dbg_rvld     (dbg_rvld),
        .dbg_rdata    (dbg_rdata),
        .imem_cen     (imem_cen),
        .imem_wen     (imem_wen),
        .imem_addr    (imem_addr),
        .imem_wr_data (imem_wr_data),
        .imem_rd_data (imem_rd_data),
        .ldr_wr_cnt   (ldr_wr_cnt)
    );

    always #5 clk = ~clk;

    // IMEM macro: synchronous read data valid the cycle after access
    logic [31:0] mem [256];
    always @(posedge clk) begin
        if (imem_cen) begin
            if (imem_wen) mem[imem_addr] <= imem_wr_data;
            else          imem_rd_data   <= mem[imem_addr];
        end
    end

    // Reference model state
    logic [31:0] ref_mem [256];
    xact_t ldr_q[$];
    xact_t dbg_q[$];
    xact_t rvld_q[$];
    logic [7:0] upper_list[$];
    logic [7:0] lower_list[$];
    int writes_issued = 0;
    int ldr_acks_seen = 0;
    int ldr_while_dbg = 0;
    logic ack_prev = 1'b0;
    logic [7:0]  last_addr_m = '0;
    logic [31:0] last_wdata_m = '0;

    int checks_total  = 0;
    int checks_passed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks_total++;
        if (act === exp) checks_passed++;
        else $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int exp_cnt();
        return (writes_issued > CNT_SAT) ? CNT_SAT : writes_issued;
    endfunction

    // Monitor: sample mid-cycle, pop expected transactions as the DUT acks them
    always @(negedge clk) begin
        xact_t e;
        if (rst) begin
            ldr_q.delete();
            dbg_q.delete();
            rvld_q.delete();
            ack_prev      = 1'b0;
            ldr_while_dbg = 0;
            last_addr_m   = '0;
            last_wdata_m  = '0;
        end else begin
            check("ifu_gnt", 64'(ifu_gnt), 64'(ifu_req & core_running));
            if (core_running) check("acks_while_running", 64'({ldr_ack, dbg_ack}), 64'(0));
            if (ifu_req && core_running) begin
                check("fetch_port", 64'({imem_cen, imem_wen, imem_addr}), 64'({1'b1, 1'b0, ifu_addr}));
                last_addr_m = ifu_addr;
            end
            if (!dbg_req) ldr_while_dbg = 0;
            if (ldr_ack) begin
                ldr_acks_seen++;
                if (ldr_q.size() == 0) begin
                    check("ldr_unexpected_ack", 64'(ldr_ack), 64'(0));
                end else begin
                    e = ldr_q.pop_front();
                    check("ldr_write_port", 64'({imem_cen, imem_wen, imem_addr, imem_wr_data}),
                          64'({2'b11, e.addr, e.data}));
                    last_addr_m  = e.addr;
                    last_wdata_m = e.data;
                    $display("ldr write addr=%02h data=%08h", e.addr, e.data);
                end
                if (dbg_req) begin
                    ldr_while_dbg++;
                    check("burst_cap", 64'(ldr_while_dbg <= TB_BURST), 64'(1));
                end
            end
            if (dbg_ack) begin
                ldr_while_dbg = 0;
                if (dbg_q.size() == 0) begin
                    check("dbg_unexpected_ack", 64'(dbg_ack), 64'(0));
                end else begin
                    e = dbg_q.pop_front();
                    check("dbg_read_port", 64'({imem_cen, imem_wen, imem_addr}), 64'({2'b10, e.addr}));
                    last_addr_m = e.addr;
                    rvld_q.push_back(e);
                end
            end
            if (!(ifu_req && core_running) && !ldr_ack && !dbg_ack) begin
                check("idle_port", 64'({imem_cen, imem_wen, imem_addr, imem_wr_data}),
                      64'({2'b00, last_addr_m, last_wdata_m}));
            end
            check("dbg_rvld_timing", 64'(dbg_rvld), 64'(ack_prev));
            if (dbg_rvld) begin
                if (rvld_q.size() == 0) begin
                    check("dbg_unexpected_rvld", 64'(dbg_rvld), 64'(0));
                end else begin
                    e = rvld_q.pop_front();
                    check("dbg_rdata", 64'(dbg_rdata), 64'(e.data));
                    $display("dbg read  addr=%02h data=%08h", e.addr, dbg_rdata);
                end
            end
            ack_prev = dbg_ack;
        end
    end

    // Loader write: present, wait for ack, optionally keep request asserted for the next one
    task automatic ldr_write(input logic [7:0] a, input logic [31:0] d, input bit keep);
        int waitc = 0;
        xact_t e;
        ldr_req = 1'b1;
        ldr_addr = a;
        ldr_data = d;
        e.addr = a;
        e.data = d;
        ldr_q.push_back(e);
        ref_mem[a] = d;
        writes_issued++;
        do begin
            @(negedge clk);
            waitc++;
        end while (!ldr_ack && waitc < 300);
        if (!ldr_ack) check("ldr_ack_timeout", 64'(ldr_ack), 64'(1));
        @(posedge clk); #1;
        if (!keep) ldr_req = 1'b0;
    endtask

    // Debug read: expected word comes from the reference memory at issue time
    task automatic dbg_read(input logic [7:0] a);
        int waitc = 0;
        xact_t e;
        dbg_req = 1'b1;
        dbg_addr = a;
        e.addr = a;
        e.data = ref_mem[a];
        dbg_q.push_back(e);
        do begin
            @(negedge clk);
            waitc++;
        end while (!dbg_ack && waitc < 300);
        if (!dbg_ack) check("dbg_ack_timeout", 64'(dbg_ack), 64'(1));
        @(posedge clk); #1;
        dbg_req = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctrl"},  64'({ifu_gnt, ldr_ack, dbg_ack, dbg_rvld, imem_cen, imem_wen}), 64'(0));
        check({tag, "_addr"},  64'(imem_addr), 64'(0));
        check({tag, "_wdata"}, 64'(imem_wr_data), 64'(0));
        check({tag, "_rdata"}, 64'(dbg_rdata), 64'(0));
        check({tag, "_cnt"},   64'(ldr_wr_cnt), 64'(0));
    endtask

    task automatic wait_ldr_acks(input int target, input string name);
        int wc = 0;
        while (ldr_acks_seen < target && wc < 300) begin
            @(negedge clk);
            wc++;
        end
        check(name, 64'(ldr_acks_seen >= target), 64'(1));
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        int base;
        int len;
        int n;
        int wc;
        logic [7:0] a;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = '0;
            ref_mem[i] = '0;
        end
        rst = 1'b1; core_running = 1'b0; ifu_req = 1'b0; ifu_addr = '0;
        ldr_req = 1'b0; ldr_addr = '0; ldr_data = '0;
        dbg_req = 1'b0; dbg_addr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: running core keeps the port, loader waits
        core_running = 1'b1; ifu_req = 1'b1; ifu_addr = 8'h10;
        fork
            ldr_write(8'h40, 32'hDEAD_0040, 1'b0);
            begin
                repeat (5) begin
                    @(negedge clk);
                    check("t1_ifu_gnt", 64'(ifu_gnt), 64'(1));
                    check("t1_imem_addr", 64'(imem_addr), 64'(8'h10));
                    check("t1_no_ldr_ack", 64'(ldr_ack), 64'(0));
                end
                @(posedge clk); #1;
                core_running = 1'b0; ifu_req = 1'b0;
            end
        join
        idle_cycles(2);

        // 2: three back-to-back loader writes, plus a word for the debug test
        for (int i = 0; i < 3; i++) ldr_write(8'(i), 32'hA0 + 32'(i), 1'b1);
        ldr_write(8'h05, 32'hC0DE_0005, 1'b0);
        idle_cycles(3);
        check("t2_wr_cnt", 64'(ldr_wr_cnt), 64'(exp_cnt()));

        // 3: held 8-write burst, debug read arrives early -> served after 4 writes
        base = ldr_acks_seen;
        fork
            for (int i = 0; i < 8; i++) ldr_write(8'h20 + 8'(i), 32'hB0 + 32'(i), i < 7);
            begin
                wait_ldr_acks(base + 1, "t3_first_ack");
                @(posedge clk); #1;
                dbg_read(8'h05);
                check("t3_burst_len", 64'(ldr_acks_seen - base), 64'(TB_BURST));
            end
        join
        idle_cycles(3);
        check("t3_wr_cnt", 64'(ldr_wr_cnt), 64'(exp_cnt()));

        // 5: core resumes mid-burst
        base = ldr_acks_seen;
        fork
            for (int i = 0; i < 6; i++) ldr_write(8'h30 + 8'(i), 32'h5500 + 32'(i), i < 5);
            begin
                wait_ldr_acks(base + 2, "t5_two_acks");
                @(posedge clk); #1;
                core_running = 1'b1; ifu_req = 1'b1; ifu_addr = 8'h77;
                @(negedge clk);
                check("t5_ifu_gnt", 64'(ifu_gnt), 64'(1));
                check("t5_no_ldr_ack", 64'(ldr_ack), 64'(0));
                idle_cycles(2);
                core_running = 1'b0; ifu_req = 1'b0;
                @(negedge clk);
                check("t5_idle_after_halt", 64'(ldr_ack), 64'(0));
            end
        join
        idle_cycles(3);

        // Random: preload upper half, then loader on lower half races debug on upper half
        for (int i = 0; i < 20; i++) begin
            a = 8'h80 | 8'($urandom_range(0, 127));
            upper_list.push_back(a);
            ldr_write(a, $urandom, 1'b0);
            idle_cycles($urandom_range(0, 2));
        end
        fork
            begin
                n = 0;
                while (n < 48) begin
                    len = $urandom_range(1, 8);
                    for (int j = 0; j < len && n < 48; j++) begin
                        a = 8'($urandom_range(0, 127));
                        lower_list.push_back(a);
                        ldr_write(a, $urandom, (j < len - 1) && (n < 47));
                        n++;
                    end
                    idle_cycles($urandom_range(0, 3));
                end
            end
            begin
                for (int k = 0; k < 16; k++) begin
                    idle_cycles($urandom_range(0, 6));
                    dbg_read(upper_list[$urandom_range(0, upper_list.size() - 1)]);
                end
            end
        join
        for (int k = 0; k < 12; k++) begin
            dbg_read(lower_list[$urandom_range(0, lower_list.size() - 1)]);
            idle_cycles($urandom_range(0, 2));
        end
        idle_cycles(3);
        check("sat_wr_cnt", 64'(ldr_wr_cnt), 64'(exp_cnt()));

        // 6: reset lands on the cycle after the debug read issue
        dbg_req = 1'b1; dbg_addr = 8'h21;
        begin
            xact_t e;
            e.addr = 8'h21;
            e.data = ref_mem[8'h21];
            dbg_q.push_back(e);
        end
        wc = 0;
        do begin
            @(negedge clk);
            wc++;
        end while (!dbg_ack && wc < 50);
        check("t6_dbg_ack", 64'(dbg_ack), 64'(1));
        #1;
        rst = 1'b1; dbg_req = 1'b0;
        @(negedge clk);
        check("t6_rvld_killed", 64'(dbg_rvld), 64'(0));
        check_reset_outputs("t6");
        @(posedge clk); #1;
        rst = 1'b0;
        writes_issued = 0;

        // 4: simultaneous requests after reset -> loader first, no same-cycle grant
        fork
            ldr_write(8'h50, 32'h4444_0050, 1'b0);
            dbg_read(8'h22);
            begin
                @(negedge clk);
                check("t4_registered_grant", 64'({ldr_ack, dbg_ack}), 64'(0));
                wc = 0;
                while (!ldr_ack && !dbg_ack && wc < 20) begin
                    @(negedge clk);
                    wc++;
                end
                check("t4_ldr_first", 64'({ldr_ack, dbg_ack}), 64'(2'b10));
            end
        join
        idle_cycles(3);
        check("t4_wr_cnt", 64'(ldr_wr_cnt), 64'(exp_cnt()));
        check("ldr_q_drained", 64'(ldr_q.size()), 64'(0));
        check("dbg_q_drained", 64'(dbg_q.size() + rvld_q.size()), 64'(0));

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
